// File: rtl/uart_inst_loader.sv
// UART program loader: receives 8N1 bytes, packs them big-endian into
// 32-bit words and writes them into instruction memory until done.
// Ports: CLK, RST_N (sync, active-low), RXD (async serial in);
// WE/WADDR/WDATA (imem write), BUSY (byte in flight), DONE (loaded),
// FRAME_ERR (sticky bad stop bit).
module uart_inst_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 6,
   parameter int MAX_WORDS    = 44
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              RXD,
   output logic              WE,
   output logic [ADDR_W-1:0] WADDR,
   output logic [31:0]       WDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              FRAME_ERR
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t state, state_nx;

   logic          rx_meta;
   logic          rxs;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_idx_nx;
   logic [7:0]    shreg, shreg_nx;
   logic [1:0]    byte_idx;
   logic [23:0]   word;
   logic          accept;
   logic          ferr_set;
   logic          last_word;

   // RX FSM: state register
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= bit_idx_nx;
         shreg   <= shreg_nx;
      end
   end

   // RX FSM: next state and byte-level events
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_idx_nx = bit_idx;
      shreg_nx   = shreg;
      accept     = 1'b0;
      ferr_set   = 1'b0;
      unique case (state)
         S_IDLE: begin
            cnt_nx     = '0;
            bit_idx_nx = '0;
            if (!rxs && !DONE)
               state_nx = S_START;
         end
         S_START: begin
            // mid-start-bit check rejects glitches
            if (cnt == HALF_LAST) begin
               cnt_nx   = '0;
               state_nx = rxs ? S_IDLE : S_DATA;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nx     = '0;
               shreg_nx   = {rxs, shreg[7:1]};
               bit_idx_nx = bit_idx + 3'd1;
               if (bit_idx == 3'd7)
                  state_nx = S_STOP;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nx   = '0;
               state_nx = S_IDLE;
               accept   = rxs;
               ferr_set = !rxs;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      // once loaded, the receiver is parked
      if (DONE)
         state_nx = S_IDLE;
   end

   assign BUSY = (state != S_IDLE);

   assign last_word = (WDATA == 32'hFFFF_FFFF) || (WADDR == ADDR_LAST);

   // synchronizer, word assembly and write port
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         byte_idx  <= '0;
         word      <= '0;
         WE        <= 1'b0;
         WADDR     <= '0;
         WDATA     <= '0;
         DONE      <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         rx_meta <= RXD;
         rxs     <= rx_meta;
         WE      <= 1'b0;
         if (ferr_set) begin
            FRAME_ERR <= 1'b1;
            byte_idx  <= '0;
         end
         if (accept) begin
            if (byte_idx == 2'd3) begin
               WE       <= 1'b1;
               WDATA    <= {word, shreg};
               byte_idx <= '0;
            end else begin
               word     <= {word[15:0], shreg};
               byte_idx <= byte_idx + 2'd1;
            end
         end
         // termination is judged on the word just written
         if (WE) begin
            if (last_word)
               DONE <= 1'b1;
            else
               WADDR <= WADDR + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_inst_loader.sv
// Bench for uart_inst_loader: two instances (capacity 44 and 4) share
// random and directed serial stimulus, checked against a word-level model.
module tb_uart_inst_loader;

   localparam int CPB = 4;
   localparam int AW  = 6;

   logic clk = 1'b0;
   logic rst_n;
   logic rxd;

   logic          we_o   [2];
   logic [AW-1:0] wa_o   [2];
   logic [31:0]   wd_o   [2];
   logic          busy_o [2];
   logic          done_o [2];
   logic          fe_o   [2];

   int checks = 0;
   int errors = 0;

   int maxw [2] = '{44, 4};

   // model (owned by stimulus process)
   logic [AW-1:0] ex_a [2][128];
   logic [31:0]   ex_d [2][128];
   bit            ex_t [2][128];
   int            wr      [2];
   int            m_bidx  [2];
   logic [31:0]   m_word  [2];
   int            m_addr  [2];
   bit            m_done  [2];
   bit            fe_sent [2];
   bit            fe_must [2];

   // observed state (owned by compare process)
   int          rd      [2];
   int          ea      [2];
   logic [31:0] ed      [2];
   bit          edone   [2];
   bit          wep     [2];
   bit          termp   [2];
   int          we_cnt  [2];
   int          last_wa [2];
   int          brun    [2];
   int          bmax    [2];

   always #5 clk = ~clk;

   uart_inst_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .MAX_WORDS(44)) u0 (
      .CLK(clk), .RST_N(rst_n), .RXD(rxd),
      .WE(we_o[0]), .WADDR(wa_o[0]), .WDATA(wd_o[0]),
      .BUSY(busy_o[0]), .DONE(done_o[0]), .FRAME_ERR(fe_o[0])
   );

   uart_inst_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .MAX_WORDS(4)) u1 (
      .CLK(clk), .RST_N(rst_n), .RXD(rxd),
      .WE(we_o[1]), .WADDR(wa_o[1]), .WDATA(wd_o[1]),
      .BUSY(busy_o[1]), .DONE(done_o[1]), .FRAME_ERR(fe_o[1])
   );

   task automatic chk(input string n, input int i,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL u%0d.%s: got %h expected %h at %0t",
                  i, n, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
               rd[i] = 0; ea[i] = 0; ed[i] = '0; edone[i] = 0;
               wep[i] = 0; termp[i] = 0; we_cnt[i] = 0;
               last_wa[i] = 0; brun[i] = 0; bmax[i] = 0;
            end else begin
               if (wep[i]) begin
                  if (termp[i]) edone[i] = 1;
                  else ea[i]++;
               end
               wep[i] = 0;
               if (we_o[i] === 1'b1) begin
                  checks++;
                  if (rd[i] >= wr[i]) begin
                     errors++;
                     $display("FAIL u%0d.unexpected_we: got addr %0d data %h expected no write",
                              i, wa_o[i], wd_o[i]);
                  end else begin
                     chk("we_addr", i, 32'(wa_o[i]), 32'(ex_a[i][rd[i]]));
                     chk("we_data", i, wd_o[i], ex_d[i][rd[i]]);
                     ed[i]    = ex_d[i][rd[i]];
                     termp[i] = ex_t[i][rd[i]];
                     rd[i]++;
                  end
                  last_wa[i] = 32'(wa_o[i]);
                  we_cnt[i]++;
                  wep[i] = 1;
               end
               chk("waddr", i, 32'(wa_o[i]), 32'(ea[i]));
               if (we_o[i] !== 1'b1)
                  chk("wdata", i, wd_o[i], ed[i]);
               chk("done", i, 32'(done_o[i]), 32'(edone[i]));
               if (!fe_sent[i])
                  chk("frame_err", i, 32'(fe_o[i]), 32'd0);
               else if (fe_must[i])
                  chk("frame_err", i, 32'(fe_o[i]), 32'd1);
               if (busy_o[i] === 1'b1) brun[i]++;
               else brun[i] = 0;
               if (brun[i] > bmax[i]) bmax[i] = brun[i];
            end
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         wr[i] = 0; m_bidx[i] = 0; m_word[i] = '0; m_addr[i] = 0;
         m_done[i] = 0; fe_sent[i] = 0; fe_must[i] = 0;
      end
   endtask

   task automatic model_byte(input int i, input logic [7:0] b, input bit good);
      bit t;
      if (m_done[i]) return;
      if (!good) begin
         m_bidx[i]  = 0;
         fe_sent[i] = 1;
         return;
      end
      m_word[i] = {m_word[i][23:0], b};
      m_bidx[i]++;
      if (m_bidx[i] == 4) begin
         t = (m_word[i] == 32'hFFFF_FFFF) || (m_addr[i] == maxw[i] - 1);
         ex_a[i][wr[i]] = AW'(m_addr[i]);
         ex_d[i][wr[i]] = m_word[i];
         ex_t[i][wr[i]] = t;
         wr[i]++;
         m_bidx[i] = 0;
         if (t) m_done[i] = 1;
         else m_addr[i]++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rxd   = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      if (n >= 2 * CPB)
         for (int i = 0; i < 2; i++) fe_must[i] = fe_sent[i];
   endtask

   task automatic bit_out(input logic v);
      rxd = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good);
      bit_out(1'b0);
      for (int k = 0; k < 8; k++) bit_out(b[k]);
      bit_out(good);
      for (int i = 0; i < 2; i++) model_byte(i, b, good);
      if (!good) idle(2 * CPB + 2);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], 1'b1);
   endtask

   task automatic glitch();
      rxd = 1'b0;
      @(posedge clk); #1;
      idle(2 * CPB);
   endtask

   logic [31:0] rw;
   bit          rg;

   initial begin
      rst_n = 1'b0;
      rxd   = 1'b1;
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // reset state
      chk("rst_we", 0, 32'(we_o[0]), 32'd0);
      chk("rst_waddr", 0, 32'(wa_o[0]), 32'd0);
      chk("rst_wdata", 0, wd_o[0], 32'd0);
      chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
      chk("rst_done", 0, 32'(done_o[0]), 32'd0);
      chk("rst_ferr", 0, 32'(fe_o[0]), 32'd0);

      // byte order
      send_word(32'h2001_0003);
      idle(6);
      chk("order_cnt", 0, 32'(we_cnt[0]), 32'd1);
      chk("order_addr", 0, 32'(last_wa[0]), 32'd0);
      chk("order_data", 0, wd_o[0], 32'h2001_0003);
      chk("order_done", 0, 32'(done_o[0]), 32'd0);
      chk("order_ferr", 0, 32'(fe_o[0]), 32'd0);
      chk("order_busy_long", 0, 32'(bmax[0] >= 9 * CPB && bmax[0] <= 10 * CPB), 32'd1);

      // sentinel
      do_reset();
      send_word(32'h2001_0003);
      send_word(32'h6C01_0000);
      send_word(32'hFFFF_FFFF);
      idle(4);
      chk("sent_done", 0, 32'(done_o[0]), 32'd1);
      send_word(32'h1234_5678);
      idle(6);
      chk("sent_cnt", 0, 32'(we_cnt[0]), 32'd3);
      chk("sent_waddr", 0, 32'(wa_o[0]), 32'd2);
      chk("sent_wdata", 0, wd_o[0], 32'hFFFF_FFFF);

      // glitch
      do_reset();
      glitch();
      idle(4);
      chk("glitch_busy_short", 0, 32'(bmax[0] <= CPB / 2 + 1), 32'd1);
      chk("glitch_busy", 0, 32'(busy_o[0]), 32'd0);
      chk("glitch_cnt", 0, 32'(we_cnt[0]), 32'd0);
      chk("glitch_ferr", 0, 32'(fe_o[0]), 32'd0);
      send_word(32'h2001_0003);
      idle(4);
      chk("glitch_addr", 0, 32'(last_wa[0]), 32'd0);
      chk("glitch_wcnt", 0, 32'(we_cnt[0]), 32'd1);

      // framing error
      do_reset();
      send_byte(8'h20, 1'b1);
      send_byte(8'h01, 1'b0);
      chk("fe_set", 0, 32'(fe_o[0]), 32'd1);
      chk("fe_nowe", 0, 32'(we_cnt[0]), 32'd0);
      send_word(32'h2001_0003);
      idle(4);
      chk("fe_cnt", 0, 32'(we_cnt[0]), 32'd1);
      chk("fe_addr", 0, 32'(last_wa[0]), 32'd0);
      chk("fe_data", 0, wd_o[0], 32'h2001_0003);
      chk("fe_sticky", 0, 32'(fe_o[0]), 32'd1);

      // capacity
      do_reset();
      for (int w = 1; w <= 5; w++) send_word(32'(w));
      idle(6);
      chk("cap_cnt", 1, 32'(we_cnt[1]), 32'd4);
      chk("cap_waddr", 1, 32'(wa_o[1]), 32'd3);
      chk("cap_wdata", 1, wd_o[1], 32'd4);
      chk("cap_done", 1, 32'(done_o[1]), 32'd1);
      chk("cap_big_cnt", 0, 32'(we_cnt[0]), 32'd5);

      // reset mid-word
      do_reset();
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      do_reset();
      chk("mid_waddr", 0, 32'(wa_o[0]), 32'd0);
      chk("mid_wdata", 0, wd_o[0], 32'd0);
      send_word(32'h6C01_0000);
      idle(4);
      chk("mid_cnt", 0, 32'(we_cnt[0]), 32'd1);
      chk("mid_addr", 0, 32'(last_wa[0]), 32'd0);
      chk("mid_data", 0, wd_o[0], 32'h6C01_0000);

      // random traffic
      for (int r = 0; r < 2; r++) begin
         do_reset();
         for (int w = 0; w < 60; w++) begin
            if ($urandom_range(0, 39) == 0) rw = 32'hFFFF_FFFF;
            else rw = $urandom;
            for (int k = 3; k >= 0; k--) begin
               rg = ($urandom_range(0, 19) != 0);
               send_byte(rw[k*8 +: 8], rg);
               if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) == 0) glitch();
         end
         idle(3 * CPB);
         for (int i = 0; i < 2; i++)
            chk("all_writes_seen", i, 32'(rd[i]), 32'(wr[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
